mem_port_arbiter: RTL and testbench

- Arbitrates the core's single memory port between the instruction-fetch requester and the data requester (load/store/call/return).
- Sits between the core control/fetch logic and a memory model with fixed MEM_LAT read latency.
- Serialises transactions one at a time with round-robin priority on contention.
- Returns big-endian data to the requester that owns the transaction.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between fetch and data.
// Optional alignment check enabled by defining MEM_ARB_ALIGN_CHK_EN.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [63:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
`ifdef MEM_ARB_ALIGN_CHK_EN
  output logic              if_err,
  output logic              d_err,
`endif
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
  localparam logic       LAT1   = (MEM_LAT == 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_owner;
  logic              r_last;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [63:0]       r_wdata;
  logic [31:0]       r_if_rdata;
  logic [63:0]       r_d_rdata;

  logic w_idle;
  logic w_gnt_d;
  logic w_gnt_f;
  logic w_gnt;
  logic w_sample;
  logic w_mis;

  // Data wins a tie unless it owned the previous transaction.
  assign w_idle   = (r_state == S_IDLE) && !reset;
  assign w_gnt_d  = w_idle && d_req && (!if_req || (r_last == OWN_F));
  assign w_gnt_f  = w_idle && if_req && !w_gnt_d;
  assign w_gnt    = w_gnt_d || w_gnt_f;
  assign w_sample = ((r_state == S_ISSUE) && LAT1) ||
                    ((r_state == S_WAIT) && (r_cnt == 4'd1));

`ifdef MEM_ARB_ALIGN_CHK_EN
  logic r_mis;

  assign w_mis  = w_gnt_d ? (d_addr[2:0] != 3'd0)
                          : (if_addr[1:0] != 2'd0);
  assign if_err = (r_state == S_RESP) && (r_owner == OWN_F) && r_mis;
  assign d_err  = (r_state == S_RESP) && (r_owner == OWN_D) && r_mis;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mis <= 1'b0;
    end else if (w_gnt) begin
      r_mis <= w_mis;
    end
  end
`else
  assign w_mis = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_owner    <= OWN_F;
      r_last     <= OWN_F;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt) begin
            r_owner <= w_gnt_d;
            r_last  <= w_gnt_d;
            r_addr  <= w_gnt_d ? d_addr : if_addr;
            r_we    <= w_gnt_d && d_we;
            r_wdata <= w_gnt_d ? d_wdata : '0;
            r_state <= w_mis ? S_RESP : S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= LAT_M1;
          r_state <= LAT1 ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Stores return zero so d_rvalid is a plain acknowledgement.
      if (w_sample) begin
        if (r_owner == OWN_D) begin
          r_d_rdata <= r_we ? 64'd0 : mem_rdata;
        end else begin
          r_if_rdata <= mem_rdata[63:32];
        end
      end
    end
  end

  assign if_gnt    = w_gnt_f;
  assign d_gnt     = w_gnt_d;
  assign if_rvalid = (r_state == S_RESP) && (r_owner == OWN_F);
  assign d_rvalid  = (r_state == S_RESP) && (r_owner == OWN_D);
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = (r_state == S_ISSUE);
  assign mem_we    = (r_state == S_ISSUE) && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a fixed-latency memory model.
// Expected responses and memory strobes are queued by stimulus, checked by monitor.
module tb_mem_port_arbiter;

  localparam int MEM_LAT = 2;
  localparam int AW      = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [63:0]   d_wdata = '0;
  logic          d_gnt;
  logic          d_rvalid;
  logic [63:0]   d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata;
  logic          busy;
`ifdef MEM_ARB_ALIGN_CHK_EN
  logic          if_err;
  logic          d_err;
`endif

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef MEM_ARB_ALIGN_CHK_EN
    .if_err(if_err), .d_err(d_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        d;
    logic        err;
    logic [63:0] data;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [63:0] wdata;
    int          cyc;
  } mem_t;

  rsp_t rsp_q[$];
  mem_t mem_q[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          due     = -1;
  logic [31:0] pend_addr = '0;

  function automatic logic [63:0] memval(logic [31:0] a);
    if (a == 32'h2000) return 64'h8840_0000_1111_2222;
    return {a ^ 32'hC0DE_0000, ~a};
  endfunction

  // Memory drives valid data only in the cycle the arbiter must sample it.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      pend_addr <= mem_addr;
      due       <= cyc + MEM_LAT - 1;
    end
  end

  assign mem_rdata = (cyc == due) ? memval(pend_addr)
                                  : 64'hA5A5_5A5A_A5A5_5A5A;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rsp(logic d, logic err, logic [63:0] data, int c);
    rsp_t e;
    e.d = d; e.err = err; e.data = data; e.cyc = c;
    rsp_q.push_back(e);
  endtask

  task automatic push_mem(logic [31:0] a, logic we, logic [63:0] wd, int c);
    mem_t m;
    m.addr = a; m.we = we; m.wdata = wd; m.cyc = c;
    mem_q.push_back(m);
  endtask

  rsp_t mon_e;
  mem_t mon_m;

  always @(negedge clk) begin
    if (!reset) begin
      if (if_rvalid || d_rvalid) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", {62'd0, if_rvalid, d_rvalid}, 64'd0);
        end else begin
          mon_e = rsp_q.pop_front();
          chk("rsp_owner", {62'd0, if_rvalid, d_rvalid},
              {62'd0, !mon_e.d, mon_e.d});
          chk("rsp_data", mon_e.d ? d_rdata : {32'd0, if_rdata}, mon_e.data);
          chk("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
`ifdef MEM_ARB_ALIGN_CHK_EN
          chk("rsp_err", {63'd0, mon_e.d ? d_err : if_err}, {63'd0, mon_e.err});
`endif
        end
      end
      if (mem_en) begin
        if (mem_q.size() == 0) begin
          chk("mem_unexpected", {63'd0, mem_en}, 64'd0);
        end else begin
          mon_m = mem_q.pop_front();
          chk("mem_addr", {32'd0, mem_addr}, {32'd0, mon_m.addr});
          chk("mem_we", {63'd0, mem_we}, {63'd0, mon_m.we});
          chk("mem_cycle", 64'(cyc), 64'(mon_m.cyc));
          if (mon_m.we) chk("mem_wdata", mem_wdata, mon_m.wdata);
        end
      end
    end
  end

  task automatic chk_zero(string tag);
    chk({tag, "_ctl"}, {57'd0, busy, mem_en, mem_we, if_gnt, d_gnt,
                        if_rvalid, d_rvalid}, 64'd0);
    chk({tag, "_maddr"}, {32'd0, mem_addr}, 64'd0);
    chk({tag, "_mwdata"}, mem_wdata, 64'd0);
    chk({tag, "_ifrd"}, {32'd0, if_rdata}, 64'd0);
    chk({tag, "_drd"}, d_rdata, 64'd0);
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1; if_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    chk("gnt_in_reset", {62'd0, if_gnt, d_gnt}, 64'd0);
    step();
    if_req = 1'b0; d_req = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk_zero("rst");
    step();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int last_g;
    int ng;
    logic nxt_d;
    logic [31:0] if_hold;
    logic [63:0] d_hold;

    do_reset();

    // Single fetch, exact timing.
    t = cyc;
    if_req = 1'b1; if_addr = 32'h2000;
    push_mem(32'h2000, 1'b0, 64'd0, t + 1);
    push_rsp(1'b0, 1'b0, 64'h8840_0000, t + 3);
    @(negedge clk);
    chk("t1_gnt", {62'd0, if_gnt, d_gnt}, 64'b10);
    step();
    if_req = 1'b0;
    @(negedge clk);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    while (cyc < t + 4) step();
    @(negedge clk);
    chk("t1_busy_low", {63'd0, busy}, 64'd0);
    chk("t1_hold", {32'd0, if_rdata}, 64'h8840_0000);

    // Tie after reset: data first.
    do_reset();
    t = cyc;
    if_req = 1'b1; if_addr = 32'h3000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1_0000; d_wdata = 64'd0;
    push_mem(32'h1_0000, 1'b0, 64'd0, t + 1);
    push_rsp(1'b1, 1'b0, memval(32'h1_0000), t + 3);
    @(negedge clk);
    chk("t2_dgnt", {62'd0, if_gnt, d_gnt}, 64'b01);
    step();
    d_req = 1'b0;
    @(negedge clk);
    chk("t2_fwait", {63'd0, if_gnt}, 64'd0);
    while (cyc < t + 4) step();
    push_mem(32'h3000, 1'b0, 64'd0, t + 5);
    push_rsp(1'b0, 1'b0, {32'd0, memval(32'h3000) >> 32}, t + 7);
    @(negedge clk);
    chk("t2_fgnt", {62'd0, if_gnt, d_gnt}, 64'b10);
    step();
    if_req = 1'b0;
    wait_idle();

    // Continuous contention for 20 cycles.
    if_req = 1'b1; if_addr = 32'h4000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
    nxt_d = 1'b1; ng = 0; last_g = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin
        chk("t3_owner", {62'd0, if_gnt, d_gnt}, {62'd0, !nxt_d, nxt_d});
        if (last_g >= 0) chk("t3_spacing", 64'(cyc - last_g), 64'd4);
        if (d_gnt) begin
          push_mem(32'h5000, 1'b0, 64'd0, cyc + 1);
          push_rsp(1'b1, 1'b0, memval(32'h5000), cyc + 3);
        end else begin
          push_mem(32'h4000, 1'b0, 64'd0, cyc + 1);
          push_rsp(1'b0, 1'b0, {32'd0, memval(32'h4000) >> 32}, cyc + 3);
        end
        last_g = cyc;
        nxt_d = !d_gnt;
        ng++;
      end
      step();
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("t3_count", 64'(ng), 64'd5);
    wait_idle();

    // Store.
    t = cyc;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'hFFF8;
    d_wdata = 64'hDEAD_BEEF_0123_4567;
    push_mem(32'hFFF8, 1'b1, 64'hDEAD_BEEF_0123_4567, t + 1);
    push_rsp(1'b1, 1'b0, 64'd0, t + 3);
    @(negedge clk);
    chk("t4_gnt", {62'd0, if_gnt, d_gnt}, 64'b01);
    step();
    d_req = 1'b0; d_we = 1'b0;
    wait_idle();

    // Reset in WAIT aborts the fetch.
    t = cyc;
    if_req = 1'b1; if_addr = 32'h7000;
    push_mem(32'h7000, 1'b0, 64'd0, t + 1);
    @(negedge clk);
    chk("t5_gnt", {62'd0, if_gnt, d_gnt}, 64'b10);
    step();
    if_req = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk_zero("t5");
    step();
    if_hold = 32'(memval(32'h6000) >> 32);
    if_req = 1'b1; if_addr = 32'h6000;
    push_mem(32'h6000, 1'b0, 64'd0, t + 5);
    push_rsp(1'b0, 1'b0, {32'd0, if_hold}, t + 7);
    @(negedge clk);
    chk("t5_regnt", {62'd0, if_gnt, d_gnt}, 64'b10);
    step();
    if_req = 1'b0;
    wait_idle();
    d_hold = 64'd0;

`ifdef MEM_ARB_ALIGN_CHK_EN
    // Misaligned accesses respond at once with err and unchanged data.
    t = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1_0004;
    push_rsp(1'b1, 1'b1, d_hold, t + 1);
    @(negedge clk);
    chk("t6_dgnt", {62'd0, if_gnt, d_gnt}, 64'b01);
    step();
    d_req = 1'b0;
    wait_idle();
    t = cyc;
    if_req = 1'b1; if_addr = 32'h2002;
    push_rsp(1'b0, 1'b1, {32'd0, if_hold}, t + 1);
    @(negedge clk);
    chk("t6_fgnt", {62'd0, if_gnt, d_gnt}, 64'b10);
    step();
    if_req = 1'b0;
    wait_idle();
`else
    // Misaligned fetch passes through to memory unmodified.
    t = cyc;
    if_req = 1'b1; if_addr = 32'h2002;
    push_mem(32'h2002, 1'b0, 64'd0, t + 1);
    push_rsp(1'b0, 1'b0, {32'd0, memval(32'h2002) >> 32}, t + 3);
    @(negedge clk);
    chk("t6_fgnt", {62'd0, if_gnt, d_gnt}, 64'b10);
    step();
    if_req = 1'b0;
    wait_idle();
    chk("t6_dhold", d_rdata, d_hold);
`endif

    repeat (4) step();
    chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    chk("mem_q_empty", 64'(mem_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
